wbuf_fifo_v3: RTL and testbench
===============================

// Module: wbuf_fifo_v3
// PURPOSE
//   Parametrised synchronous FIFO for the cache write-through path; buffers write
//   requests (address+data+strobe words) between the cache front-end and the memory
//   back-end. Uses all 2**ADDR_W entries, selectable standard or first-word-fall-through
//   read mode, programmable almost-full/almost-empty flags, occupancy level output,
//   synchronous flush and sticky overflow/underflow error flags.
// PARAMETERS
//   DATA_W    66  word width in bits
//   ADDR_W    2   log2(depth); depth = 2**ADDR_W entries, ADDR_W >= 1
//   FWFT      0   0 = standard read (registered dataout), 1 = first-word-fall-through
//   AF_LVL    3   almost_full asserted when level >= AF_LVL (1..2**ADDR_W)
//   AE_LVL    1   almost_empty asserted when level <= AE_LVL (0..2**ADDR_W-1)
// PORTS
//   clock         in   1         rising-edge clock
//   reset         in   1         asynchronous, active-high reset
//   flush         in   1         synchronous clear of contents and error flags
//   we            in   1         write request
//   datain        in   DATA_W    write data
//   rd            in   1         read request (FWFT=1: pop head)
//   dataout       out  DATA_W    read data
//   full          out  1         level == 2**ADDR_W
//   almost_full   out  1         level >= AF_LVL
//   empty         out  1         level == 0
//   almost_empty  out  1         level <= AE_LVL
//   level         out  ADDR_W+1  current occupancy, 0..2**ADDR_W
//   overflow      out  1         sticky: we while full and not accepted
//   underflow     out  1         sticky: rd while empty
// BEHAVIOUR
// - Reset (async): rd/wr pointers=0, level=0, empty=1, full=0, almost_full=0,
//   almost_empty=1, overflow=0, underflow=0, registered dataout=0. Memory not reset.
// - Pointers ADDR_W bits, wrap modulo 2**ADDR_W; level is an ADDR_W+1-bit register.
// - rd_ok = rd & ~empty & ~flush. wr_ok = we & ~flush & (~full | rd_ok): write into a
//   full FIFO accepted only with a same-cycle accepted read; level unchanged.
// - Write to empty FIFO with rd=1: read rejected (no bypass); underflow set.
// - level_nxt: +1 on wr_ok&~rd_ok, -1 on rd_ok&~wr_ok, else hold.
//   All flags derived combinationally from the level register.
// - FWFT=0: on rd_ok, dataout <= mem[rd_ptr] at the next edge (1-cycle latency);
//   dataout holds until the next rd_ok, including across flush and empty.
// - FWFT=1: dataout = mem[rd_ptr] combinationally; valid whenever empty=0; a write
//   is visible at dataout the cycle after it is accepted; rd_ok advances the head.
// - flush: next edge pointers=0, level=0, overflow=underflow=0; we/rd that cycle
//   ignored and do not set error flags. reset dominates flush.
// - overflow set at edge when we & full & ~rd_ok & ~flush; underflow set when
//   rd & empty & ~flush. Both hold until flush or reset.
// - No combinational path from datain to dataout when FWFT=0.
// TESTING (DATA_W=8, ADDR_W=2, AF_LVL=3, AE_LVL=1)
//   1 reset, write 0x11,0x22,0x33,0x44 -> level 1..4, almost_full at level 3,
//     full at 4; 5th write 0x55 -> rejected, overflow=1, level stays 4.
//   2 FWFT=0, full FIFO, 4 reads -> dataout 0x11,0x22,0x33,0x44 one cycle after each
//     rd; empty=1 after last; extra rd -> underflow=1, dataout holds 0x44.
//   3 full FIFO, we=1 rd=1 same cycle with 0x66 -> both accepted, level stays 4;
//     drain -> 0x22,0x33,0x44,0x66.
//   4 FWFT=1, write 0xA5 to empty -> next cycle dataout=0xA5, empty=0; rd -> empty=1.
//   5 level 3 with overflow=1, assert flush with we=1 -> level=0, empty=1,
//     overflow=0, write not stored; then write 0x77/read returns 0x77.
//   6 reset asserted mid-burst (level 2) -> all outputs at reset values
//     asynchronously; pointers restart at 0 after release.

Source files
------------

// File: rtl/wbuf_fifo_v3.sv
// Write-buffer FIFO for the cache write-through path. It uses all 2**ADDR_W entries.
// Read mode is either registered or first-word-fall-through, and the error flags are sticky.
module wbuf_fifo_v3 #(
  parameter int DATA_W = 66,
  parameter int ADDR_W = 2,
  parameter int FWFT   = 0,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              we,
  input  logic [DATA_W-1:0] datain,
  input  logic              rd,
  output logic [DATA_W-1:0] dataout,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AF   = (ADDR_W + 1)'(AF_LVL);
  localparam logic [ADDR_W:0] LVL_AE   = (ADDR_W + 1)'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              rd_ok, wr_ok;

  assign level        = level_q;
  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);

  // A full FIFO still takes a write when a read drains a slot in the same cycle.
  assign rd_ok = rd & ~empty & ~flush;
  assign wr_ok = we & ~flush & (~full | rd_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      overflow  <= overflow | (we & full & ~rd_ok);
      underflow <= underflow | (rd & empty);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= datain;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dataout = mem[rd_ptr];
    end else begin : g_std
      // The registered output keeps the last word that was popped, through flush and empty.
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)      dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_ptr];
      end
      assign dataout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_wbuf_fifo_v3.sv
// Directed bench for wbuf_fifo_v3. One instance runs in standard read mode and one in FWFT mode.
// The expected values are computed by hand from the FIFO behaviour.
module tb_wbuf_fifo_v3;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       we = 1'b0, rd = 1'b0;
  logic [7:0] datain = '0, dataout;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [2:0] level;

  logic       we1 = 1'b0, rd1 = 1'b0;
  logic [7:0] datain1 = '0, dataout1;
  logic       full1, almost_full1, empty1, almost_empty1, overflow1, underflow1;
  logic [2:0] level1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  wbuf_fifo_v3 #(.DATA_W(8), .ADDR_W(2), .FWFT(0), .AF_LVL(3), .AE_LVL(1)) u_dut (
    .clock(clock), .reset(reset), .flush(flush), .we(we), .datain(datain), .rd(rd),
    .dataout(dataout), .full(full), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .level(level), .overflow(overflow), .underflow(underflow)
  );

  wbuf_fifo_v3 #(.DATA_W(8), .ADDR_W(2), .FWFT(1), .AF_LVL(3), .AE_LVL(1)) u_dut_fwft (
    .clock(clock), .reset(reset), .flush(1'b0), .we(we1), .datain(datain1), .rd(rd1),
    .dataout(dataout1), .full(full1), .almost_full(almost_full1), .empty(empty1),
    .almost_empty(almost_empty1), .level(level1), .overflow(overflow1), .underflow(underflow1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    we = 1'b1; datain = d; tick(); we = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  logic [7:0] exp_fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_drain [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

  initial begin
    // 1: reset values, fill to full, then a rejected fifth write
    reset = 1'b1;
    #12;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_dout", dataout, 0);
    chk("rst_empty_fwft", empty1, 1);
    reset = 1'b0;
    tick();

    push(8'h11); chk("w1_level", level, 1); chk("w1_ae", almost_empty, 1); chk("w1_empty", empty, 0);
    push(8'h22); chk("w2_level", level, 2); chk("w2_ae", almost_empty, 0); chk("w2_af", almost_full, 0);
    push(8'h33); chk("w3_level", level, 3); chk("w3_af", almost_full, 1); chk("w3_full", full, 0);
    push(8'h44); chk("w4_level", level, 4); chk("w4_full", full, 1);
    push(8'h55); chk("w5_level", level, 4); chk("w5_ovf", overflow, 1);

    // 2: drain in order with one cycle of latency, then an underflow
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("rd_dout", dataout, exp_fill[i]);
      chk("rd_level", level, 3 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_unf_pre", underflow, 0);
    pop();
    chk("unf_set", underflow, 1);
    chk("unf_dout_hold", dataout, 8'h44);

    // 3: simultaneous write and read on a full FIFO
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("refill_full", full, 1);
    we = 1'b1; rd = 1'b1; datain = 8'h66; tick(); we = 1'b0; rd = 1'b0;
    chk("wr_rd_full_level", level, 4);
    chk("wr_rd_full_dout", dataout, 8'h11);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("drain3_dout", dataout, exp_drain[i]);
    end
    chk("drain3_empty", empty, 1);

    // 5: flush at level 3 with errors set and a write pending
    push(8'h01); push(8'h02); push(8'h03);
    chk("pre_flush_level", level, 3);
    chk("pre_flush_ovf", overflow, 1);
    flush = 1'b1; we = 1'b1; datain = 8'h99; tick(); flush = 1'b0; we = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_unf", underflow, 0);
    chk("flush_dout_hold", dataout, 8'h66);
    push(8'h77);
    chk("post_flush_level", level, 1);
    pop();
    chk("post_flush_dout", dataout, 8'h77);

    // 4: FWFT instance
    we1 = 1'b1; datain1 = 8'hA5; tick(); we1 = 1'b0;
    chk("fwft_dout", dataout1, 8'hA5);
    chk("fwft_empty", empty1, 0);
    rd1 = 1'b1; tick(); rd1 = 1'b0;
    chk("fwft_rd_empty", empty1, 1);
    we1 = 1'b1; datain1 = 8'h3C; tick();
    datain1 = 8'h5A; tick(); we1 = 1'b0;
    chk("fwft_head", dataout1, 8'h3C);
    rd1 = 1'b1; tick(); rd1 = 1'b0;
    chk("fwft_next", dataout1, 8'h5A);
    rd1 = 1'b1; tick();
    chk("fwft_empty2", empty1, 1);
    we1 = 1'b1; datain1 = 8'hC3; tick(); we1 = 1'b0; rd1 = 1'b0;
    chk("fwft_nobypass_level", level1, 1);
    chk("fwft_nobypass_unf", underflow1, 1);
    chk("fwft_nobypass_dout", dataout1, 8'hC3);

    // 6: asynchronous reset in the middle of a burst
    push(8'hE1); push(8'hE2);
    chk("pre_rst_level", level, 3'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ae", almost_empty, 1);
    chk("arst_dout", dataout, 0);
    chk("arst_fwft_level", level1, 0);
    #1 reset = 1'b0;
    tick();
    push(8'hAB); push(8'hCD);
    pop();
    chk("ptr_restart_dout", dataout, 8'hAB);
    chk("ptr_restart_level", level, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end of test, expected finish before 50000");
    $fatal(1);
  end
endmodule
